pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register for the RV32IM pipeline. It is a drop-in replacement for the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. Each payload is split into a data field and a control field. A two-entry skid buffer provides valid/ready flow control, so backpressure costs no bubbles. It also supports a global BUSYWAIT freeze and a synchronous FLUSH that inserts a bubble, with bubble control values forced to a safe NOP encoding.

## Interface
- DATA_WIDTH, 133, width of the data field (rd, PC, DATA1, DATA2, IMMEDIATE for an ID/EX instance).
- CTRL_WIDTH, 15, width of the control field (sel, ALU op, branch/jump, mem, WB, reg-write bits).
- DATA_RESET, 0, value loaded into both data entries on reset.
- CTRL_BUBBLE, 0, control value presented whenever the stage holds no valid entry. It must encode "no write, no memory access, no branch".
- CLK  in  1  clock; all state updates on the posedge.
- RESET  in  1  asynchronous, active-high reset.
- BUSYWAIT  in  1  global freeze from memory; no transfers while high.
- FLUSH  in  1  synchronous kill of all held and incoming entries.
- IN_VALID  in  1  upstream has a payload.
- IN_READY  out  1  stage can accept; registered.
- IN_DATA  in  DATA_WIDTH  upstream data field.
- IN_CTRL  in  CTRL_WIDTH  upstream control field.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  DATA_WIDTH  head entry data.
- OUT_CTRL  out  CTRL_WIDTH  head entry control, or CTRL_BUBBLE when OUT_VALID=0.
- OCCUPANCY  out  2  number of held entries (0..2).

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry has its own valid bit.
- Transfer qualifiers:
  - accept = IN_VALID & IN_READY & !BUSYWAIT.
  - issue = OUT_VALID & OUT_READY & !BUSYWAIT.
- IN_READY = !skid_valid & !RESET. It depends only on registered state and never combinationally on OUT_READY.
- Next-state rules, in priority order:
  - FLUSH=1: main_valid and skid_valid become 0. Any accept in the same cycle is consumed and discarded. FLUSH overrides BUSYWAIT. Data registers keep their old values.
  - BUSYWAIT=1 (no FLUSH): all state holds.
  - main empty & accept: main <= input.
  - main full & issue & skid full: main <= skid, skid empty. Accept is impossible here because IN_READY=0.
  - main full & issue & accept: main <= input.
  - main full & issue & no accept: main empty.
  - main full & !issue & accept: skid <= input.
  - otherwise: hold.
- Ordering is strictly FIFO. The skid entry is never presented while the main entry is valid.
- OUT_CTRL = main_valid ? main_ctrl : CTRL_BUBBLE. OUT_DATA always shows main_data, including stale data when invalid.
- OCCUPANCY = main_valid + skid_valid.
- Reset (asynchronous, takes effect immediately and holds while RESET=1):
  - main_valid = skid_valid = 0; OUT_VALID=0; IN_READY=0.
  - OUT_DATA = DATA_RESET; OUT_CTRL = CTRL_BUBBLE; OCCUPANCY=0.
  - Skid data and control are reset to DATA_RESET and CTRL_BUBBLE.
- Reset mid-operation drops all entries without a flush handshake. After RESET deasserts, IN_READY=1 immediately.

## Timing
- Latency: a payload accepted at posedge N appears on OUT_* after posedge N (visible in cycle N+1).
- Throughput: 1 payload per cycle with OUT_READY held high; zero bubbles.
- Backpressure: a single OUT_READY=0 cycle during streaming puts the next payload in the skid entry. IN_READY falls after that edge and rises one cycle after the skid drains.
- FLUSH takes effect at the posedge where it is sampled. OUT_VALID=0 and OUT_CTRL=CTRL_BUBBLE from the next cycle. A payload offered in the following cycle is accepted normally.
- BUSYWAIT high for k cycles stretches every in-flight timing by exactly k cycles and loses no data.
- No combinational path from IN_VALID/IN_DATA/IN_CTRL to any output. OUT_CTRL depends combinationally only on registered state.

## Test plan
- Reset: assert RESET asynchronously mid-cycle with 2 entries held -> OUT_VALID=0, OCCUPANCY=0, IN_READY=0, OUT_CTRL=CTRL_BUBBLE, OUT_DATA=DATA_RESET, all without waiting for a clock edge. Release RESET -> IN_READY=1.
- Streaming: IN_VALID=1 with data 1..8 on consecutive cycles, OUT_READY=1 -> OUT_DATA shows 1..8 on consecutive cycles, each one cycle late, with OUT_VALID continuously 1.
- Backpressure: stream 1..6 and drop OUT_READY for 2 cycles after 2 appears -> OCCUPANCY reaches 2, IN_READY=0 for those cycles, and output order is 1..6 with no loss or duplication.
- Flush: hold 2 entries and pulse FLUSH while IN_VALID=1 with data 0xA5 -> next cycle OUT_VALID=0, OCCUPANCY=0, OUT_CTRL=CTRL_BUBBLE, and 0xA5 never appears at the output.
- BUSYWAIT: assert for 3 cycles mid-stream with OUT_READY=1 -> outputs and OCCUPANCY frozen, no accepts; the stream resumes in order afterwards.
- Corner case: FLUSH and BUSYWAIT together with OCCUPANCY=2 -> OCCUPANCY=0 after the edge. Then issue and accept in the same cycle with skid empty -> main replaced by the input and OCCUPANCY stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Elastic pipeline-stage register, two-entry skid buffer with
//            freeze (BUSYWAIT) and bubble-inserting FLUSH.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int                    DATA_WIDTH  = 133,
  parameter int                    CTRL_WIDTH  = 15,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET  = '0,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUSYWAIT,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  output logic [1:0]            OCCUPANCY
);

  logic                  r_main_valid;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;

  logic w_in_ready;
  logic w_accept;
  logic w_issue;

  // Ready comes only from the skid flag, so downstream stalls never ripple upstream combinationally.
  assign w_in_ready = ~r_skid_valid & ~RESET;
  assign w_accept   = IN_VALID & w_in_ready & ~BUSYWAIT;
  assign w_issue    = r_main_valid & OUT_READY & ~BUSYWAIT;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_main_valid <= 1'b0;
      r_main_data  <= DATA_RESET;
      r_main_ctrl  <= CTRL_BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= DATA_RESET;
      r_skid_ctrl  <= CTRL_BUBBLE;
    end else if (FLUSH) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!BUSYWAIT) begin
      if (!r_main_valid) begin
        if (w_accept) begin
          r_main_valid <= 1'b1;
          r_main_data  <= IN_DATA;
          r_main_ctrl  <= IN_CTRL;
        end
      end else if (w_issue) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_ctrl  <= r_skid_ctrl;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_data  <= IN_DATA;
          r_main_ctrl  <= IN_CTRL;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= IN_DATA;
        r_skid_ctrl  <= IN_CTRL;
      end
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = r_main_valid;
  assign OUT_DATA  = r_main_data;
  assign OUT_CTRL  = r_main_valid ? r_main_ctrl : CTRL_BUBBLE;
  assign OCCUPANCY = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed vector table, async-reset sequence and randomized run
//            against a queue-based model of pipe_stage_reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int         c_DW     = 16;
  localparam int         c_CW     = 4;
  localparam logic [15:0] c_DRST  = 16'hDEAD;
  localparam logic [3:0]  c_BUB   = 4'h9;

  logic            CLK, RESET, BUSYWAIT, FLUSH, IN_VALID, IN_READY;
  logic [c_DW-1:0] IN_DATA, OUT_DATA;
  logic [c_CW-1:0] IN_CTRL, OUT_CTRL;
  logic            OUT_VALID, OUT_READY;
  logic [1:0]      OCCUPANCY;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .DATA_WIDTH (c_DW),
    .CTRL_WIDTH (c_CW),
    .DATA_RESET (c_DRST),
    .CTRL_BUBBLE(c_BUB)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUSYWAIT (BUSYWAIT),
    .FLUSH    (FLUSH),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .IN_CTRL  (IN_CTRL),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_CTRL (OUT_CTRL),
    .OCCUPANCY(OCCUPANCY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit          iv, bsy, fl, ordy;
    logic [15:0] d;
    logic [3:0]  c;
    logic [1:0]  eocc;
    bit          ev, erdy;
    logic [15:0] ed;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[13];

  // Model: the stage is a FIFO of at most two payloads.
  logic [19:0] q[$];
  logic [15:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit iss, acc;
    if (FLUSH) begin
      q.delete();
    end else if (!BUSYWAIT) begin
      iss = (q.size() > 0) && OUT_READY;
      acc = IN_VALID && (q.size() < 2);
      if (iss) void'(q.pop_front());
      if (acc) q.push_back({IN_DATA, IN_CTRL});
    end
    if (q.size() > 0) m_last = q[0][19:4];
  endtask

  task automatic model_check();
    logic [19:0] h;
    chk("rnd_occ",   {30'd0, OCCUPANCY}, q.size());
    chk("rnd_valid", {31'd0, OUT_VALID}, (q.size() > 0) ? 1 : 0);
    chk("rnd_ready", {31'd0, IN_READY},  (q.size() < 2) ? 1 : 0);
    chk("rnd_data",  {16'd0, OUT_DATA},  {16'd0, m_last});
    if (q.size() > 0) begin
      h = q[0];
      chk("rnd_ctrl", {28'd0, OUT_CTRL}, {28'd0, h[3:0]});
    end else begin
      chk("rnd_ctrl", {28'd0, OUT_CTRL}, {28'd0, c_BUB});
    end
  endtask

  initial begin
    tbl[0]  = '{1,0,0,1, 16'h0001, 4'h1, 2'd1, 1, 1, 16'h0001, 4'h1};
    tbl[1]  = '{1,0,0,1, 16'h0002, 4'h2, 2'd1, 1, 1, 16'h0002, 4'h2};
    tbl[2]  = '{1,0,0,0, 16'h0003, 4'h3, 2'd2, 1, 0, 16'h0002, 4'h2};
    tbl[3]  = '{1,0,0,0, 16'h0004, 4'h4, 2'd2, 1, 0, 16'h0002, 4'h2};
    tbl[4]  = '{1,0,0,1, 16'h0004, 4'h4, 2'd1, 1, 1, 16'h0003, 4'h3};
    tbl[5]  = '{1,0,0,0, 16'h0004, 4'h4, 2'd2, 1, 0, 16'h0003, 4'h3};
    tbl[6]  = '{1,1,0,1, 16'h0005, 4'h5, 2'd2, 1, 0, 16'h0003, 4'h3};
    tbl[7]  = '{0,1,1,1, 16'h0000, 4'h0, 2'd0, 0, 1, 16'h0003, c_BUB};
    tbl[8]  = '{1,0,0,1, 16'h00A5, 4'h5, 2'd1, 1, 1, 16'h00A5, 4'h5};
    tbl[9]  = '{1,0,1,1, 16'h0006, 4'h6, 2'd0, 0, 1, 16'h00A5, c_BUB};
    tbl[10] = '{0,0,0,1, 16'h0000, 4'h0, 2'd0, 0, 1, 16'h00A5, c_BUB};
    tbl[11] = '{1,0,0,1, 16'h0007, 4'h7, 2'd1, 1, 1, 16'h0007, 4'h7};
    tbl[12] = '{0,0,0,1, 16'h0000, 4'h0, 2'd0, 0, 1, 16'h0007, c_BUB};

    RESET = 1'b1; BUSYWAIT = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
    OUT_READY = 1'b0; IN_DATA = '0; IN_CTRL = '0;
    repeat (2) @(negedge CLK);
    chk("rst_occ",   {30'd0, OCCUPANCY}, 0);
    chk("rst_valid", {31'd0, OUT_VALID}, 0);
    chk("rst_ready", {31'd0, IN_READY},  0);
    chk("rst_data",  {16'd0, OUT_DATA},  {16'd0, c_DRST});
    chk("rst_ctrl",  {28'd0, OUT_CTRL},  {28'd0, c_BUB});
    RESET = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, IN_READY}, 1);

    // Directed vectors, one clock each, checked on the following negedge.
    @(negedge CLK);
    for (int i = 0; i < 13; i++) begin
      IN_VALID = tbl[i].iv; BUSYWAIT = tbl[i].bsy; FLUSH = tbl[i].fl;
      OUT_READY = tbl[i].ordy; IN_DATA = tbl[i].d; IN_CTRL = tbl[i].c;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("vec%0d_occ", i),   {30'd0, OCCUPANCY}, {30'd0, tbl[i].eocc});
      chk($sformatf("vec%0d_valid", i), {31'd0, OUT_VALID}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, IN_READY},  {31'd0, tbl[i].erdy});
      chk($sformatf("vec%0d_data", i),  {16'd0, OUT_DATA},  {16'd0, tbl[i].ed});
      chk($sformatf("vec%0d_ctrl", i),  {28'd0, OUT_CTRL},  {28'd0, tbl[i].ec});
    end
    BUSYWAIT = 1'b0; FLUSH = 1'b0;

    // Async reset with two held entries, observed before any clock edge.
    IN_VALID = 1'b1; OUT_READY = 1'b0; IN_DATA = 16'h0011; IN_CTRL = 4'h1;
    @(posedge CLK); @(negedge CLK);
    IN_DATA = 16'h0022; IN_CTRL = 4'h2;
    @(posedge CLK); @(negedge CLK);
    chk("full_occ", {30'd0, OCCUPANCY}, 2);
    IN_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("arst_occ",   {30'd0, OCCUPANCY}, 0);
    chk("arst_valid", {31'd0, OUT_VALID}, 0);
    chk("arst_ready", {31'd0, IN_READY},  0);
    chk("arst_ctrl",  {28'd0, OUT_CTRL},  {28'd0, c_BUB});
    chk("arst_data",  {16'd0, OUT_DATA},  {16'd0, c_DRST});
    RESET = 1'b0;
    #1;
    chk("arst_rel_ready", {31'd0, IN_READY}, 1);

    q.delete();
    m_last = c_DRST;
    @(negedge CLK);
    for (int n = 0; n < 600; n++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      BUSYWAIT  = ($urandom_range(0, 7) == 0);
      FLUSH     = ($urandom_range(0, 15) == 0);
      IN_DATA   = 16'($urandom);
      IN_CTRL   = 4'($urandom);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      model_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
